ahb_initializer: RTL and testbench
==================================

// Module: ahb_initializer
// PURPOSE
//  AHB-Lite-style bus master that runs once after reset and fetches five tagged
//  configuration words: width, height, read start address, write start address
//  and filter type. It holds them on outputs for the downstream datapath.
//  It then raises final_enable to start the pipeline.
// PARAMETERS
//  BUSWIDTH  32            data/address bus width
//  CFG_BASE  32'h0000_0D00 address of first config word; field k at CFG_BASE+4*k
// PORTS
//  ahb_hclk           in   1   sole clock; all logic on rising edge
//  n_rst              in   1   reset, synchronous, ACTIVE-HIGH (1 = reset)
//  ahb_htrans         out  2   IDLE=2'b00, NONSEQ=2'b10
//  ahb_hburst         out  3   always SINGLE=3'b000
//  ahb_hwrite         out  1   always 0 (reads only)
//  ahb_hprot          out  1   always 1 (data access)
//  ahb_haddr          out  32  transfer address
//  ahb_hwdata         out  32  always 0
//  ahb_hrdata         in   32  read data
//  ahb_hgrant         in   1   bus grant
//  ahb_hlock          out  1   always 0
//  ahb_hbusreq        out  1   bus request
//  ahb_hready         in   1   transfer ready / wait-state control
//  ahb_hresp          in   2   OKAY=00, ERROR=01 (others treated as ERROR)
//  width, height      out  32  configured image dimensions
//  readStartAddress   out  32  source frame base
//  writeStartAddress  out  32  destination frame base
//  filterType         out  1   filter select
//  final_enable       out  1   configuration complete, pipeline go
// BEHAVIOUR
//  Reset (n_rst=1 at clk edge):
//   - state=IDLE; all config outputs and final_enable = 0.
//   - htrans=IDLE, hbusreq=0, haddr=0.
//  Word format: [31:29] tag, [28:0] payload.
//   - Tags: width=3'b001, height=3'b010, readStart=3'b011, writeStart=3'b100, filter=3'b101.
//   - Stored value = {3'b000, payload}; filterType = hrdata[0].
//  States:
//   - IDLE -> ADDR1 on first cycle out of reset.
//   - ADDRk/DATAk for k=1..5 (width, height, readStart, writeStart, filter).
//   - Then KICKSTART -> DONE.
//  ADDRk:
//   - hbusreq=1; haddr = CFG_BASE+4*(k-1).
//   - htrans=NONSEQ only while hgrant=1, else IDLE.
//   - Advance to DATAk when hgrant & hready.
//  DATAk:
//   - htrans=IDLE; wait while hready=0.
//   - On hready=1 & hresp=OKAY & tag ok: latch field, go ADDR(k+1). ADDR6 is KICKSTART.
//   - On hready=1 & hresp!=OKAY: no latch, return to ADDRk (retry, unbounded).
//  KICKSTART: hbusreq=0; final_enable=1.
//  DONE: final_enable held 1; outputs frozen; terminal state until reset.
//  Latency: zero wait states with hgrant tied 1 gives final_enable high 11 cycles after reset release.
//  Reset asserted mid-sequence aborts immediately: all outputs reset, bus returns to IDLE.
//  A field register updates only in its own DATAk accept cycle.
// CONFIGURATION
//  TAG_CHECK_EN defined: tag ok = (hrdata[31:29] == expected tag).
//   - Mismatch with OKAY response is treated like ERROR: re-read the same word.
//  TAG_CHECK_EN undefined: tag bits ignored; payload still masked to 29 bits.
// STRUCTURE
//  Package initializer_pkg holds:
//   - state enum; TAG_* constants; HTRANS_*, HBURST_SINGLE, HRESP_* constants.
//  One sub-module: ahb_single_read. It is the generic ADDR/DATA single-read handshake engine.
//   - Inputs: req, addr. Outputs: done, err, rdata.
//   - The top-level FSM sequences the five fields through it.
// TESTING
//  T1 hgrant=hready=1; words 0x20000151, 0x40000151, 0x600001F4, 0x8000157C, 0xA0000001
//     -> width=0x151, height=0x151, readStartAddress=0x1F4, writeStartAddress=0x157C,
//        filterType=1, final_enable=1 and stays 1.
//  T2 hready=0 for 3 cycles in DATA2 -> height latched only after hready=1; no extra transfer issued.
//  T3 hresp=ERROR in DATA3 -> haddr=CFG_BASE+8 reissued; readStartAddress stays 0 until OKAY.
//  T4 TAG_CHECK_EN, word1=0x40000151 then 0x20000010 -> first word rejected, width=0x10.
//  T5 hgrant=0 for 5 cycles -> htrans=IDLE and hbusreq=1 throughout; transfer starts on grant.
//  T6 n_rst=1 during DATA4 -> next cycle all outputs 0, state IDLE; full sequence reruns correctly.

Source files
------------

// File: rtl/initializer_pkg.sv
// Shared types and AHB constants for the configuration-fetch master.
// Tag checking of fetched words is enabled by defining TAG_CHECK_EN.
package initializer_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StAddr1, StData1,
        StAddr2, StData2,
        StAddr3, StData3,
        StAddr4, StData4,
        StAddr5, StData5,
        StKickstart,
        StDone
    } init_state_e;

    localparam logic [2:0] TAG_WIDTH       = 3'b001;
    localparam logic [2:0] TAG_HEIGHT      = 3'b010;
    localparam logic [2:0] TAG_READ_START  = 3'b011;
    localparam logic [2:0] TAG_WRITE_START = 3'b100;
    localparam logic [2:0] TAG_FILTER      = 3'b101;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    function automatic logic is_addr_state(init_state_e st);
        return st inside {StAddr1, StAddr2, StAddr3, StAddr4, StAddr5};
    endfunction

    function automatic logic is_data_state(init_state_e st);
        return st inside {StData1, StData2, StData3, StData4, StData5};
    endfunction

    // Field 0..4 for any ADDRk/DATAk state (states are laid out in pairs after StIdle).
    function automatic logic [2:0] field_index(init_state_e st);
        logic [3:0] v;
        v = st - 4'd1;
        return v[3:1];
    endfunction

    function automatic logic [2:0] field_tag(logic [2:0] idx);
        logic [2:0] tag;
        unique case (idx)
            3'd0:    tag = TAG_WIDTH;
            3'd1:    tag = TAG_HEIGHT;
            3'd2:    tag = TAG_READ_START;
            3'd3:    tag = TAG_WRITE_START;
            default: tag = TAG_FILTER;
        endcase
        return tag;
    endfunction

endpackage

// File: rtl/ahb_single_read.sv
// Generic single-beat AHB read engine: address phase waits for grant, data phase
// waits for hready and reports done (OKAY) or err (any other response).
module ahb_single_read
    import initializer_pkg::*;
#(
    parameter int unsigned BUSWIDTH = 32
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                req,
    input  logic [BUSWIDTH-1:0] addr,
    input  logic                hgrant,
    input  logic                hready,
    input  logic [1:0]          hresp,
    input  logic [BUSWIDTH-1:0] hrdata,
    output logic [1:0]          htrans,
    output logic                hbusreq,
    output logic [BUSWIDTH-1:0] haddr,
    output logic                launch,
    output logic                done,
    output logic                err,
    output logic [BUSWIDTH-1:0] rdata
);

    typedef enum logic {PhAddr, PhData} phase_e;

    phase_e phase_q, phase_d;

    always_ff @(posedge clk) begin
        if (n_rst) begin
            phase_q <= PhAddr;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        htrans  = HTRANS_IDLE;
        hbusreq = 1'b0;
        haddr   = '0;
        launch  = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        if (req) begin
            hbusreq = 1'b1;
            haddr   = addr;
            unique case (phase_q)
                PhAddr: begin
                    if (hgrant) begin
                        htrans = HTRANS_NONSEQ;
                    end
                    if (hgrant && hready) begin
                        launch  = 1'b1;
                        phase_d = PhData;
                    end
                end
                PhData: begin
                    if (hready) begin
                        phase_d = PhAddr;
                        done    = (hresp == HRESP_OKAY);
                        err     = (hresp != HRESP_OKAY);
                    end
                end
                default: phase_d = PhAddr;
            endcase
        end else begin
            phase_d = PhAddr;
        end
    end

    assign rdata = hrdata;

endmodule

// File: rtl/ahb_initializer.sv
// One-shot AHB master that fetches five tagged config words after reset, holds them,
// then raises final_enable. Define TAG_CHECK_EN to re-read words whose tag mismatches.
module ahb_initializer
    import initializer_pkg::*;
#(
    parameter int unsigned          BUSWIDTH = 32,
    parameter logic [BUSWIDTH-1:0]  CFG_BASE = 32'h0000_0D00
) (
    input  logic                ahb_hclk,
    input  logic                n_rst,
    output logic [1:0]          ahb_htrans,
    output logic [2:0]          ahb_hburst,
    output logic                ahb_hwrite,
    output logic                ahb_hprot,
    output logic [BUSWIDTH-1:0] ahb_haddr,
    output logic [BUSWIDTH-1:0] ahb_hwdata,
    input  logic [BUSWIDTH-1:0] ahb_hrdata,
    input  logic                ahb_hgrant,
    output logic                ahb_hlock,
    output logic                ahb_hbusreq,
    input  logic                ahb_hready,
    input  logic [1:0]          ahb_hresp,
    output logic [BUSWIDTH-1:0] width,
    output logic [BUSWIDTH-1:0] height,
    output logic [BUSWIDTH-1:0] readStartAddress,
    output logic [BUSWIDTH-1:0] writeStartAddress,
    output logic                filterType,
    output logic                final_enable
);

    init_state_e         state_q, state_d;
    logic [2:0]          field_idx;
    logic                req;
    logic [BUSWIDTH-1:0] rd_addr;
    logic                launch, done, err;
    logic [BUSWIDTH-1:0] rdata;
    logic [BUSWIDTH-1:0] payload;
    logic                tag_ok;
    logic                accept, retry;

    logic [BUSWIDTH-1:0] width_q, height_q, read_start_q, write_start_q;
    logic                filter_q;

    assign field_idx = field_index(state_q);
    assign req       = is_addr_state(state_q) || is_data_state(state_q);
    assign rd_addr   = CFG_BASE + BUSWIDTH'({field_idx, 2'b00});

    ahb_single_read #(
        .BUSWIDTH (BUSWIDTH)
    ) u_read (
        .clk     (ahb_hclk),
        .n_rst   (n_rst),
        .req     (req),
        .addr    (rd_addr),
        .hgrant  (ahb_hgrant),
        .hready  (ahb_hready),
        .hresp   (ahb_hresp),
        .hrdata  (ahb_hrdata),
        .htrans  (ahb_htrans),
        .hbusreq (ahb_hbusreq),
        .haddr   (ahb_haddr),
        .launch  (launch),
        .done    (done),
        .err     (err),
        .rdata   (rdata)
    );

    assign payload = {3'b000, rdata[BUSWIDTH-4:0]};

`ifdef TAG_CHECK_EN
    assign tag_ok = (rdata[BUSWIDTH-1 -: 3] == field_tag(field_idx));
`else
    logic unused_tag;
    assign tag_ok     = 1'b1;
    assign unused_tag = ^rdata[BUSWIDTH-1 -: 3];
`endif

    // A wrong tag under an OKAY response is handled exactly like a bus error.
    assign accept = done && tag_ok;
    assign retry  = err || (done && !tag_ok);

    always_ff @(posedge ahb_hclk) begin
        if (n_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      state_d = StAddr1;
            StKickstart: state_d = StDone;
            StDone:      state_d = StDone;
            default: begin
                if (is_addr_state(state_q) && launch) begin
                    state_d = init_state_e'(state_q + 4'd1);
                end else if (is_data_state(state_q) && accept) begin
                    state_d = init_state_e'(state_q + 4'd1);
                end else if (is_data_state(state_q) && retry) begin
                    state_d = init_state_e'(state_q - 4'd1);
                end
            end
        endcase
    end

    always_ff @(posedge ahb_hclk) begin
        if (n_rst) begin
            width_q       <= '0;
            height_q      <= '0;
            read_start_q  <= '0;
            write_start_q <= '0;
            filter_q      <= 1'b0;
        end else if (accept) begin
            case (field_idx)
                3'd0:    width_q       <= payload;
                3'd1:    height_q      <= payload;
                3'd2:    read_start_q  <= payload;
                3'd3:    write_start_q <= payload;
                3'd4:    filter_q      <= rdata[0];
                default: ;
            endcase
        end
    end

    assign width             = width_q;
    assign height            = height_q;
    assign readStartAddress  = read_start_q;
    assign writeStartAddress = write_start_q;
    assign filterType        = filter_q;
    assign final_enable      = (state_q == StKickstart) || (state_q == StDone);

    assign ahb_hburst = HBURST_SINGLE;
    assign ahb_hwrite = 1'b0;
    assign ahb_hprot  = 1'b1;
    assign ahb_hwdata = '0;
    assign ahb_hlock  = 1'b0;

endmodule

// File: tb/tb_ahb_initializer.sv
// Directed bench for ahb_initializer with a small single-beat AHB slave model.
module tb_ahb_initializer;
    import initializer_pkg::*;

    logic        clk;
    logic        n_rst;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic        hwrite;
    logic        hprot;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hgrant;
    logic        hlock;
    logic        hbusreq;
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] width, height, rd_start, wr_start;
    logic        filter_type;
    logic        final_enable;

    logic [31:0] mem [0:7];
    logic [31:0] dp_addr;
    int          nonseq_cnt;
    logic        resp_err;
    int          errors;
    int          checks;

    ahb_initializer #(
        .BUSWIDTH (32),
        .CFG_BASE (32'h0000_0D00)
    ) dut (
        .ahb_hclk          (clk),
        .n_rst             (n_rst),
        .ahb_htrans        (htrans),
        .ahb_hburst        (hburst),
        .ahb_hwrite        (hwrite),
        .ahb_hprot         (hprot),
        .ahb_haddr         (haddr),
        .ahb_hwdata        (hwdata),
        .ahb_hrdata        (hrdata),
        .ahb_hgrant        (hgrant),
        .ahb_hlock         (hlock),
        .ahb_hbusreq       (hbusreq),
        .ahb_hready        (hready),
        .ahb_hresp         (hresp),
        .width             (width),
        .height            (height),
        .readStartAddress  (rd_start),
        .writeStartAddress (wr_start),
        .filterType        (filter_type),
        .final_enable      (final_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign hrdata = mem[dp_addr[4:2]];
    assign hresp  = resp_err ? HRESP_ERROR : HRESP_OKAY;

    // Slave side: latch the address of every accepted NONSEQ and count them.
    always @(posedge clk) begin
        if (n_rst) begin
            nonseq_cnt <= 0;
            dp_addr    <= 32'h0;
        end else if (htrans == HTRANS_NONSEQ && hready && hgrant) begin
            nonseq_cnt <= nonseq_cnt + 1;
            dp_addr    <= haddr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic load_words();
        mem[0] = 32'h2000_0151;
        mem[1] = 32'h4000_0151;
        mem[2] = 32'h6000_01F4;
        mem[3] = 32'h8000_157C;
        mem[4] = 32'hA000_0001;
        mem[5] = 32'h0;
        mem[6] = 32'h0;
        mem[7] = 32'h0;
    endtask

    task automatic do_reset();
        n_rst = 1'b1;
        tick();
        tick();
        n_rst = 1'b0;
    endtask

    task automatic wait_final(input int budget);
        for (int i = 0; i < budget && final_enable !== 1'b1; i++) tick();
        check("final_enable_timeout", {31'h0, final_enable}, 32'h1);
    endtask

    task automatic check_fields(input string tag, input logic [31:0] exp_width);
        check({tag, "_width"}, width, exp_width);
        check({tag, "_height"}, height, 32'h151);
        check({tag, "_rdstart"}, rd_start, 32'h1F4);
        check({tag, "_wrstart"}, wr_start, 32'h157C);
        check({tag, "_filter"}, {31'h0, filter_type}, 32'h1);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        hgrant   = 1'b1;
        hready   = 1'b1;
        resp_err = 1'b0;
        n_rst    = 1'b1;
        load_words();

        // Reset state
        tick();
        tick();
        check("rst_htrans", {30'h0, htrans}, 32'h0);
        check("rst_hbusreq", {31'h0, hbusreq}, 32'h0);
        check("rst_haddr", haddr, 32'h0);
        check("rst_final", {31'h0, final_enable}, 32'h0);
        check("rst_width", width, 32'h0);
        check("rst_consts", {hburst, hwrite, hprot, hlock}, {3'b000, 1'b0, 1'b1, 1'b0});
        check("rst_hwdata", hwdata, 32'h0);

        // T1: zero wait states, exact latency
        n_rst = 1'b0;
        tick();
        check("t1_addr1_haddr", haddr, 32'h0D00);
        check("t1_addr1_htrans", {30'h0, htrans}, {30'h0, HTRANS_NONSEQ});
        check("t1_addr1_busreq", {31'h0, hbusreq}, 32'h1);
        repeat (9) tick();
        check("t1_final_early", {31'h0, final_enable}, 32'h0);
        check("t1_wrstart_c10", wr_start, 32'h157C);
        check("t1_filter_c10", {31'h0, filter_type}, 32'h0);
        tick();
        check("t1_final_c11", {31'h0, final_enable}, 32'h1);
        check("t1_busreq_kick", {31'h0, hbusreq}, 32'h0);
        repeat (5) tick();
        check("t1_final_hold", {31'h0, final_enable}, 32'h1);
        check("t1_htrans_done", {30'h0, htrans}, 32'h0);
        check("t1_nonseq", nonseq_cnt, 32'd5);
        check_fields("t1", 32'h151);

        // T2: three wait states in DATA2
        do_reset();
        repeat (4) tick();
        hready = 1'b0;
        repeat (3) tick();
        check("t2_height_wait", height, 32'h0);
        check("t2_width", width, 32'h151);
        check("t2_htrans_wait", {30'h0, htrans}, 32'h0);
        check("t2_nonseq_wait", nonseq_cnt, 32'd2);
        hready = 1'b1;
        tick();
        check("t2_height_acc", height, 32'h151);
        wait_final(30);
        check("t2_nonseq", nonseq_cnt, 32'd5);
        check_fields("t2", 32'h151);

        // T3: ERROR response in DATA3 forces a reissue
        do_reset();
        repeat (6) tick();
        resp_err = 1'b1;
        tick();
        resp_err = 1'b0;
        check("t3_retry_haddr", haddr, 32'h0D08);
        check("t3_retry_htrans", {30'h0, htrans}, {30'h0, HTRANS_NONSEQ});
        check("t3_rdstart_err", rd_start, 32'h0);
        tick();
        check("t3_rdstart_data", rd_start, 32'h0);
        tick();
        check("t3_rdstart_ok", rd_start, 32'h1F4);
        wait_final(30);
        check("t3_nonseq", nonseq_cnt, 32'd6);
        check_fields("t3", 32'h151);

`ifdef TAG_CHECK_EN
        // T4: wrong tag on word 1 is re-read
        mem[0] = 32'h4000_0151;
        do_reset();
        repeat (3) tick();
        check("t4_reject_haddr", haddr, 32'h0D00);
        check("t4_reject_width", width, 32'h0);
        mem[0] = 32'h2000_0010;
        wait_final(30);
        check("t4_nonseq", nonseq_cnt, 32'd6);
        check_fields("t4", 32'h10);
`else
        // T4: tag bits ignored, payload still masked to 29 bits
        mem[0] = 32'hE000_0151;
        do_reset();
        wait_final(30);
        check("t4_nonseq", nonseq_cnt, 32'd5);
        check_fields("t4", 32'h151);
`endif
        load_words();

        // T5: grant withheld for five cycles
        hgrant = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_htrans_nogrant", {30'h0, htrans}, 32'h0);
            check("t5_busreq_nogrant", {31'h0, hbusreq}, 32'h1);
        end
        check("t5_haddr_nogrant", haddr, 32'h0D00);
        hgrant = 1'b1;
        #1;
        check("t5_htrans_grant", {30'h0, htrans}, {30'h0, HTRANS_NONSEQ});
        wait_final(30);
        check("t5_nonseq", nonseq_cnt, 32'd5);
        check_fields("t5", 32'h151);

        // T6: reset during DATA4 aborts, then a clean rerun
        do_reset();
        repeat (8) tick();
        check("t6_height_pre", height, 32'h151);
        n_rst = 1'b1;
        tick();
        check("t6_width_rst", width, 32'h0);
        check("t6_height_rst", height, 32'h0);
        check("t6_rdstart_rst", rd_start, 32'h0);
        check("t6_htrans_rst", {30'h0, htrans}, 32'h0);
        check("t6_busreq_rst", {31'h0, hbusreq}, 32'h0);
        check("t6_haddr_rst", haddr, 32'h0);
        check("t6_final_rst", {31'h0, final_enable}, 32'h0);
        n_rst = 1'b0;
        tick();
        check("t6_restart_haddr", haddr, 32'h0D00);
        wait_final(30);
        check("t6_nonseq", nonseq_cnt, 32'd5);
        check_fields("t6", 32'h151);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
